mrr_ook_packet_tx: RTL and testbench
====================================

// Module: mrr_ook_packet_tx
// PURPOSE
//  Transmit-side counterpart of the MRR header correlator/decoder pathway. Takes payload words on an AXI-stream,
//  frames each packet as header bits + payload bits + recharge gap, and emits an OOK-modulated 16b I/Q sample
//  stream in the same format the correlation pathway consumes. Used as on-FPGA stimulus and loopback source.
// PARAMETERS
//  HEADER_MAX_BITS    32   max header length; header_word is sent MSB-first, top header_len bits
//  SPB_WIDTH          16   width of samples_per_bit
//  GAP_WIDTH          15   width of recharge_len (matches receiver recharge setting)
// PORTS
//  clk               in   1    system clock
//  rst               in   1    asynchronous reset, active-low
//  s_tdata           in   32   payload word, MSB sent first
//  s_tvalid          in   1    payload word valid
//  s_tlast           in   1    last word of packet
//  s_tready          out  1    word accepted when s_tvalid & s_tready
//  header_word       in   32   header bit pattern
//  header_len        in   6    header bits to send (1..32; 0 treated as 32)
//  num_payload_bits  in   8    payload bits per packet (0 = header-only)
//  samples_per_bit   in   16   output samples per bit (0 treated as 1)
//  amplitude         in   16   I value for an "on" sample
//  recharge_len      in   15   zero samples appended after each packet
//  o_tdata_i         out  16   I sample
//  o_tdata_q         out  16   Q sample (always 0)
//  o_tvalid          out  1    sample valid
//  o_tlast           out  1    last sample of recharge gap (end of packet)
//  o_tready          in   1    downstream ready
//  tx_busy           out  1    high from first header sample to o_tlast handshake
//  pkt_count         out  16   packets completed, wraps at 2^16
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0. Asserting rst mid-packet aborts immediately; no partial o_tlast.
//  Config (header_*, num_payload_bits, samples_per_bit, amplitude, recharge_len) latched on IDLE->HEADER; later
//   changes take effect next packet only.
//  Output register advances when (!o_tvalid | o_tready); o_tdata/o_tlast held stable while o_tvalid & !o_tready.
//  FSM:
//   IDLE    : s_tready=1 if num_payload_bits!=0; on s_tvalid handshake latch word -> HEADER.
//             if num_payload_bits==0, any s_tvalid handshake (word discarded) starts header-only packet.
//   HEADER  : emit header_len bits x samples_per_bit samples; then PAYLOAD (or GAP if no payload bits).
//   PAYLOAD : emit num_payload_bits bits from shift reg; after 32 bits of a word, pop next word (s_tready
//             one cycle). If next word unavailable, stall output (o_tvalid=0) -- no bubbles inside a bit.
//             If s_tlast word exhausted before num_payload_bits, remaining bits sent as 0.
//             If num_payload_bits reached before s_tlast, remaining words drained and discarded in GAP.
//   GAP     : emit recharge_len zero samples; o_tlast on final one (recharge_len=0 -> o_tlast on last payload
//             sample); on o_tlast handshake pkt_count++ -> IDLE.
//  Sample value: bit=1 -> I=amplitude; bit=0 -> I=0; Q=0 always.
//  Counters: sample_cnt 0..samples_per_bit-1, bit_cnt 0..N-1; 1-cycle latency from handshake to first sample.
//  Back-to-back packets: IDLE lasts exactly one cycle when s_tvalid held high.
// CONFIGURATION
//  MRR_TX_MANCHESTER_EN defined: each bit split into two halves of floor(samples_per_bit/2) and the remainder;
//   bit=1 -> on/off, bit=0 -> off/on; header and payload both encoded; gap unaffected. samples_per_bit<2 -> 2.
//  Undefined: plain NRZ OOK as above; logic for half-bit split absent.
// TESTING
//  1 header=0xB4000000,len=8,spb=4,payload=0,gap=2,amp=0x4000 -> I seq 4000x4,0x4,4000x8,0x4,4000x4,0x8,0x2; tlast on 34th.
//  2 payload 40 bits, words 0xFFFFFFFF,0x80000000(tlast) -> 32 ones then 1,0x7 ; second word popped exactly once.
//  3 o_tready toggled 1/0 every cycle during test 2 -> identical sample sequence, data stable while stalled.
//  4 num_payload_bits=40, single tlast word -> last 8 bits zero; num_payload_bits=8, 2 words -> 2nd word drained.
//  5 rst low mid-PAYLOAD -> next cycle o_tvalid=0,tx_busy=0,pkt_count=0; next packet starts clean from header.
//  6 MRR_TX_MANCHESTER_EN, spb=4, header=0xC0000000,len=2 -> I: amp,amp,0,0,amp,amp,0,0.

Source files
------------

// File: rtl/mrr_ook_packet_tx.sv
// mrr_ook_packet_tx: frames AXI-stream payload words as header + payload + recharge gap and emits OOK I/Q samples.
// Ports:
//   clk, rst (async, active-low)
//   s_tdata/s_tvalid/s_tlast/s_tready : payload words in, MSB sent first
//   header_word, header_len           : header pattern (MSB-first), length 1..32 (0 means 32)
//   num_payload_bits                  : payload bits per packet (0 = header-only)
//   samples_per_bit, amplitude        : samples per bit (0 means 1), I value of an "on" sample
//   recharge_len                      : zero samples appended after each packet
//   o_tdata_i/o_tdata_q/o_tvalid/o_tlast/o_tready : sample stream out, o_tlast on final packet sample
//   tx_busy, pkt_count                : packet in flight, completed packet counter
// Build option: MRR_TX_MANCHESTER_EN selects Manchester bit encoding instead of NRZ.
module mrr_ook_packet_tx #(
   parameter int HEADER_MAX_BITS = 32,
   parameter int SPB_WIDTH       = 16,
   parameter int GAP_WIDTH       = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                s_tdata,
   input  logic                       s_tvalid,
   input  logic                       s_tlast,
   output logic                       s_tready,
   input  logic [HEADER_MAX_BITS-1:0] header_word,
   input  logic [5:0]                 header_len,
   input  logic [7:0]                 num_payload_bits,
   input  logic [SPB_WIDTH-1:0]       samples_per_bit,
   input  logic [15:0]                amplitude,
   input  logic [GAP_WIDTH-1:0]       recharge_len,
   output logic [15:0]                o_tdata_i,
   output logic [15:0]                o_tdata_q,
   output logic                       o_tvalid,
   output logic                       o_tlast,
   input  logic                       o_tready,
   output logic                       tx_busy,
   output logic [15:0]                pkt_count
);
   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} state_t;
   state_t state, state_nx;
   logic [HEADER_MAX_BITS-1:0] hdr_sr;
   logic [31:0]                pay_sr;
   logic [7:0]                 hlen_r, npb_r, bit_cnt;
   logic [SPB_WIDTH-1:0]       spb_r, sample_cnt;
   logic [GAP_WIDTH-1:0]       rlen_r, gap_cnt;
   logic [15:0]                amp_r;
   logic [4:0]                 wbit;
   logic need, last_seen, fin, sent, act;
   logic adv, spb_end, hdr_end, pay_end, gap_end, tl_hs, drained;
   logic emit, bit_v, dat, last, on;

   assign o_tdata_q = 16'd0;
   assign adv       = !o_tvalid || o_tready;
   assign spb_end   = sample_cnt == spb_r - SPB_WIDTH'(1);
   assign hdr_end   = bit_cnt == hlen_r - 8'd1;
   assign pay_end   = bit_cnt == npb_r - 8'd1;
   assign gap_end   = gap_cnt == rlen_r - GAP_WIDTH'(1);
   assign tl_hs     = o_tvalid && o_tready && o_tlast;
   // trailing words after the payload limit must be swallowed before the next packet may start
   assign drained   = last_seen || (s_tvalid && s_tlast);

`ifdef MRR_TX_MANCHESTER_EN
   assign on = dat && (bit_v ? (sample_cnt < (spb_r >> 1)) : (sample_cnt >= (spb_r >> 1)));
`else
   assign on = dat && bit_v;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      s_tready = 1'b0;
      emit     = 1'b0;
      bit_v    = 1'b0;
      dat      = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            s_tready = act;
            if (s_tvalid && act) state_nx = HEADER;
         end
         HEADER: begin
            bit_v = hdr_sr[HEADER_MAX_BITS-1];
            dat   = 1'b1;
            emit  = adv;
            last  = spb_end && hdr_end && npb_r == 8'd0 && rlen_r == '0;
            if (emit && spb_end && hdr_end) state_nx = (npb_r != 8'd0) ? PAYLOAD : GAP;
         end
         PAYLOAD: begin
            bit_v    = pay_sr[31];
            dat      = 1'b1;
            s_tready = need;
            // a missing next word stalls at a bit boundary, never inside a bit
            emit     = adv && !need;
            last     = spb_end && pay_end && rlen_r == '0;
            if (emit && spb_end && pay_end) state_nx = GAP;
         end
         default: begin
            s_tready = !last_seen;
            emit     = adv && !fin;
            last     = gap_end;
            if (fin && (tl_hs || sent) && drained) state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_tvalid   <= 1'b0;
         o_tlast    <= 1'b0;
         o_tdata_i  <= 16'd0;
         tx_busy    <= 1'b0;
         pkt_count  <= 16'd0;
         hdr_sr     <= '0;
         pay_sr     <= 32'd0;
         hlen_r     <= 8'd0;
         npb_r      <= 8'd0;
         spb_r      <= '0;
         rlen_r     <= '0;
         amp_r      <= 16'd0;
         sample_cnt <= '0;
         bit_cnt    <= 8'd0;
         gap_cnt    <= '0;
         wbit       <= 5'd0;
         need       <= 1'b0;
         last_seen  <= 1'b0;
         fin        <= 1'b0;
         sent       <= 1'b0;
         act        <= 1'b0;
      end else begin
         act <= 1'b1;
         if (adv) begin
            o_tvalid  <= emit;
            o_tlast   <= emit && last;
            o_tdata_i <= (emit && on) ? amp_r : 16'd0;
         end
         if (tl_hs) begin
            pkt_count <= pkt_count + 16'd1;
            tx_busy   <= 1'b0;
            sent      <= 1'b1;
         end else if (emit) tx_busy <= 1'b1;
         if (state == IDLE && s_tvalid && act) begin
            hdr_sr <= header_word;
            hlen_r <= (header_len == 6'd0) ? 8'(HEADER_MAX_BITS) : {2'b00, header_len};
            npb_r  <= num_payload_bits;
`ifdef MRR_TX_MANCHESTER_EN
            spb_r  <= (samples_per_bit < SPB_WIDTH'(2)) ? SPB_WIDTH'(2) : samples_per_bit;
`else
            spb_r  <= (samples_per_bit == '0) ? SPB_WIDTH'(1) : samples_per_bit;
`endif
            amp_r      <= amplitude;
            rlen_r     <= recharge_len;
            sample_cnt <= '0;
            bit_cnt    <= 8'd0;
            gap_cnt    <= '0;
            wbit       <= 5'd0;
            need       <= 1'b0;
            fin        <= 1'b0;
            sent       <= 1'b0;
            pay_sr     <= s_tdata;
            // header-only packets consume exactly the one triggering word
            last_seen  <= s_tlast || num_payload_bits == 8'd0;
         end
         if (emit) begin
            if (state == GAP) gap_cnt <= gap_cnt + GAP_WIDTH'(1);
            else begin
               sample_cnt <= spb_end ? '0 : sample_cnt + SPB_WIDTH'(1);
               if (spb_end) begin
                  bit_cnt <= ((state == HEADER) ? hdr_end : pay_end) ? 8'd0 : bit_cnt + 8'd1;
                  if (state == HEADER) hdr_sr <= hdr_sr << 1;
                  else begin
                     // zeros shift in once the tlast word is exhausted
                     pay_sr <= pay_sr << 1;
                     wbit   <= wbit + 5'd1;
                     need   <= wbit == 5'd31 && !last_seen && !pay_end;
                  end
               end
            end
            if (last) fin <= 1'b1;
         end
         if (s_tvalid && s_tready && state != IDLE) begin
            last_seen <= s_tlast;
            if (need) begin
               pay_sr <= s_tdata;
               need   <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_mrr_ook_packet_tx.sv
// tb_mrr_ook_packet_tx: scoreboard bench for mrr_ook_packet_tx with directed packet vectors.
`timescale 1ns/1ps
module tb_mrr_ook_packet_tx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_tdata = 32'd0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic        s_tready;
   logic [31:0] header_word = 32'd0;
   logic [5:0]  header_len = 6'd0;
   logic [7:0]  num_payload_bits = 8'd0;
   logic [15:0] samples_per_bit = 16'd0;
   logic [15:0] amplitude = 16'd0;
   logic [14:0] recharge_len = 15'd0;
   logic [15:0] o_tdata_i, o_tdata_q, pkt_count;
   logic        o_tvalid, o_tlast, tx_busy;
   logic        o_tready = 1'b1;
   logic        tog = 1'b0;

   typedef struct {logic [15:0] i; logic l;} smp_t;
   typedef struct {logic [31:0] d; logic l;} wrd_t;
   smp_t eq[$];
   wrd_t wq[$];
   int n_chk = 0, n_fail = 0, acc = 0, hs_cnt = 0;

   always #5 clk = ~clk;

   mrr_ook_packet_tx dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .header_word(header_word), .header_len(header_len), .num_payload_bits(num_payload_bits),
      .samples_per_bit(samples_per_bit), .amplitude(amplitude), .recharge_len(recharge_len),
      .o_tdata_i(o_tdata_i), .o_tdata_q(o_tdata_q), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
      .o_tready(o_tready), .tx_busy(tx_busy), .pkt_count(pkt_count)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (sample %0d)", name, got, exp, acc);
      end
   endtask

   task automatic run(input logic [15:0] v, input int n, input logic l = 1'b0);
      for (int k = 0; k < n; k++) eq.push_back(smp_t'{i: v, l: l && k == n - 1});
   endtask

   task automatic word(input logic [31:0] d, input logic l);
      wq.push_back(wrd_t'{d: d, l: l});
   endtask

   task automatic cfg(input logic [31:0] hw, input logic [5:0] hl, input logic [7:0] npb,
                      input logic [15:0] spb, input logic [15:0] amp, input logic [14:0] gap);
      header_word = hw; header_len = hl; num_payload_bits = npb;
      samples_per_bit = spb; amplitude = amp; recharge_len = gap;
   endtask

   task automatic wait_done(input string name, input logic [15:0] pc);
      int k = 0;
      while ((pkt_count !== pc || eq.size() != 0 || tx_busy !== 1'b0) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_timeout: pkt_count %0d, required %0d, %0d samples outstanding", name, pkt_count, pc, eq.size());
      end
      check({name, "_pkt_count"}, 32'(pkt_count), 32'(pc));
      check({name, "_busy_low"}, 32'(tx_busy), 32'd0);
      check({name, "_samples_left"}, 32'(eq.size()), 32'd0);
   endtask

   task automatic exp_t1();
      run(16'h4000, 4); run(16'h0, 4); run(16'h4000, 8); run(16'h0, 4);
      run(16'h4000, 4); run(16'h0, 8); run(16'h0, 2, 1'b1);
   endtask

   task automatic exp_t2();
      run(16'h1234, 2); run(16'h0, 2);
      run(16'h1234, 64); run(16'h1234, 2); run(16'h0, 14);
      run(16'h0, 3, 1'b1);
   endtask

   // monitor: every presented sample must match the scoreboard head, including while stalled
   always @(negedge clk) begin
      if (rst && o_tvalid) begin
         if (eq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sample_unexpected: got i=%h last=%b, required no sample", o_tdata_i, o_tlast);
         end else begin
            check("sample_i", 32'(o_tdata_i), 32'(eq[0].i));
            check("sample_last", 32'(o_tlast), 32'(eq[0].l));
            check("sample_q", 32'(o_tdata_q), 32'd0);
            check("busy_while_valid", 32'(tx_busy), 32'd1);
            if (o_tready) begin
               void'(eq.pop_front());
               acc++;
            end
         end
      end
   end

   // word feeder: presents the head of wq, pops it once it has been handshaken
   initial forever begin
      logic hs;
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (hs && wq.size() > 0) begin
         void'(wq.pop_front());
         hs_cnt++;
      end
      if (wq.size() > 0) begin
         s_tdata = wq[0].d; s_tlast = wq[0].l; s_tvalid = 1'b1;
      end else s_tvalid = 1'b0;
   end

   initial forever begin
      @(posedge clk);
      #1;
      o_tready = tog ? ~o_tready : 1'b1;
   end

   initial begin
      int hs0, acc0, k;
      #3 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tvalid", 32'(o_tvalid), 32'd0);
      check("reset_tlast", 32'(o_tlast), 32'd0);
      check("reset_busy", 32'(tx_busy), 32'd0);
      check("reset_pkt_count", 32'(pkt_count), 32'd0);
      check("reset_tready", 32'(s_tready), 32'd0);
      @(posedge clk);
      #2 rst = 1'b1;
`ifdef MRR_TX_MANCHESTER_EN
      cfg(32'hC000_0000, 6'd2, 8'd0, 16'd4, 16'h5A5A, 15'd0);
      run(16'h5A5A, 2); run(16'h0, 2); run(16'h5A5A, 2); run(16'h0, 2, 1'b1);
      word(32'h0, 1'b1);
      wait_done("t6_manchester", 16'd1);
`else
      cfg(32'hB400_0000, 6'd8, 8'd0, 16'd4, 16'h4000, 15'd2);
      exp_t1();
      word(32'hDEAD_BEEF, 1'b1);
      wait_done("t1_header_only", 16'd1);

      hs0 = hs_cnt;
      cfg(32'hA000_0000, 6'd2, 8'd40, 16'd2, 16'h1234, 15'd3);
      exp_t2();
      word(32'hFFFF_FFFF, 1'b0); word(32'h8000_0000, 1'b1);
      wait_done("t2_two_words", 16'd2);
      check("t2_word_pops", 32'(hs_cnt - hs0), 32'd2);

      hs0 = hs_cnt;
      tog = 1'b1;
      exp_t2();
      word(32'hFFFF_FFFF, 1'b0); word(32'h8000_0000, 1'b1);
      wait_done("t3_backpressure", 16'd3);
      check("t3_word_pops", 32'(hs_cnt - hs0), 32'd2);
      tog = 1'b0;

      cfg(32'h8000_0000, 6'd1, 8'd40, 16'd1, 16'h7FFF, 15'd0);
      run(16'h7FFF, 1); run(16'h0, 24); run(16'h7FFF, 8); run(16'h0, 8, 1'b1);
      word(32'h0000_00FF, 1'b1);
      wait_done("t4_short_last_word", 16'd4);

      hs0 = hs_cnt;
      cfg(32'h0000_0001, 6'd0, 8'd8, 16'd0, 16'h0100, 15'd2);
      run(16'h0, 31); run(16'h0100, 1);
      run(16'h0100, 1); run(16'h0, 1); run(16'h0100, 1); run(16'h0, 2);
      run(16'h0100, 1); run(16'h0, 1); run(16'h0100, 1);
      run(16'h0, 2, 1'b1);
      word(32'hA500_0000, 1'b0); word(32'hFFFF_FFFF, 1'b1);
      wait_done("t4_drain", 16'd5);
      check("t4_drain_pops", 32'(hs_cnt - hs0), 32'd2);
      check("t4_drain_queue", 32'(wq.size()), 32'd0);

      cfg(32'hA000_0000, 6'd2, 8'd40, 16'd2, 16'h1234, 15'd3);
      exp_t2();
      word(32'hFFFF_FFFF, 1'b0); word(32'h8000_0000, 1'b1);
      acc0 = acc;
      k = 0;
      while (acc < acc0 + 10 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 1000) begin
         n_chk++;
         n_fail++;
         $display("FAIL t5_reach_payload: accepted %0d samples, required 10", acc - acc0);
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      eq.delete();
      wq.delete();
      s_tvalid = 1'b0;
      @(negedge clk);
      check("t5_abort_tvalid", 32'(o_tvalid), 32'd0);
      check("t5_abort_busy", 32'(tx_busy), 32'd0);
      check("t5_abort_pkt_count", 32'(pkt_count), 32'd0);
      @(posedge clk);
      #2 rst = 1'b1;
      cfg(32'hB400_0000, 6'd8, 8'd0, 16'd4, 16'h4000, 15'd2);
      exp_t1();
      word(32'h1234_5678, 1'b1);
      wait_done("t5_restart", 16'd1);
`endif
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
